boe_frame_sched: RTL
====================

Name: boe_frame_sched

Overview:
- Round-robin scheduler that shares one BOE statistics engine (sum / min / descending sort of 1-6 bytes) between two requesters.
- It buffers a requester's frame locally, then holds the engine in reset between frames. Each frame is released into the engine as one uninterrupted burst.
- It captures the engine's fixed-timing result stream and returns it to the owning requester.
- It sits between the requester-side data movers and the single BOE instance.

Parameters:
- DATA_W, 8, data byte width (engine-fixed).
- RES_W, 11, result width (engine-fixed).
- MAX_N, 6, maximum frame length.
- TIMEOUT, 64, LOAD idle-cycle limit (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- reqK  in  1  frame request from requester K, K in {0,1}.
- lenK  in  3  frame length; legal range 1..6.
- dinK  in  8  frame data byte.
- din_validK  in  1  data valid.
- din_readyK  out  1  data ready.
- resK  out  11  returned result word.
- res_validK  out  1  result word valid.
- res_lastK  out  1  final result word of the frame.
- rejK  out  1  one-cycle reject pulse.
- eng_rst  out  1  engine reset, active-high, registered.
- eng_data_num  out  3  frame length to the engine.
- eng_data_in  out  8  data byte to the engine.
- eng_result  in  11  engine result.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values: state=IDLE, eng_rst=1, rr_last=1 (req0 wins first), all res*/valid/last/rej/din_ready=0, busy=0.
- IDLE:
  - Requesters eligible when reqK=1 and lenK is 1..6.
  - Round-robin grant: the requester other than rr_last wins if it is eligible.
  - Latch the grantee ID, N=len and rr_last on the grant edge, then go to LOAD.
  - reqK=1 with lenK of 0 or 7 gives rejK=1 that cycle, no grant.
  - req and len are sampled only in IDLE.
- LOAD:
  - din_readyK=1 for the grantee only, while count<N.
  - A byte is accepted when valid&ready and written to buf[count].
  - On the edge accepting byte N-1: state goes to BURST and eng_rst goes to 0.
  - Dropping reqK during LOAD has no effect.
- BURST, k=0..N-1:
  - eng_data_num=N and eng_data_in=buf[k], both combinational.
  - Both are 0 in every other state.
- DRAIN, k=N..2N+2:
  - eng_data_num=0.
  - eng_result carries sum at k=N+1, min at k=N+2, and sorted values (largest first) at k=N+3..2N+2.
  - Each of these N+2 words is registered to resK/res_validK one cycle later.
  - res_lastK is set with the word from k=2N+2.
  - At k=2N+2, state returns to IDLE and eng_rst goes to 1. The engine gets at least one reset cycle between frames.
- No result backpressure: requesters must accept every valid word.
- Frame cost from grant cycle: 1 + (LOAD cycles) + 2N+3, plus 1 IDLE cycle.
- Arithmetic: sum of up to 6×255=1530 fits in 11 bits. min and sorted values are zero-extended bytes.
- rst asserted in any state: immediate return to reset values; the engine is held in reset; the partial frame is discarded with no result words.
- While one requester is served, the other's req is held pending and gets no rej.

Optional Feature:
- Macro: BOE_SCHED_LOAD_TIMEOUT_EN.
- Defined:
  - A counter is cleared on each accepted byte and on entry to LOAD.
  - If TIMEOUT consecutive LOAD cycles pass without an accepted byte, the frame is aborted: rejK pulses for 1 cycle, the state returns to IDLE, eng_rst stays 1, and no result words are produced.
- Undefined: LOAD waits indefinitely; the counter logic is absent.

Test Plan:
- Single frame: req0=1, len0=3, data 5,9,2 supplied back-to-back → 3 BURST cycles with eng_rst=0. res0 stream: 16, 2, 9, 5, 2, with res_last0 on the final 2. Then eng_rst=1 and busy=0.
- Contention: req0 and req1 both with len=2 after reset → req0 is served first, then req1. With req0 held continuously, grants alternate 1,0,1.
- Illegal length: req1=1, len1=7 (and separately len1=0) → rej1=1 every IDLE cycle, no din_ready1, eng_rst stays 1.
- Maximum frame: len0=6, all bytes 255, with din_valid toggled to stall LOAD → sum 1530, min 255, then six 255 words. The BURST stays contiguous despite the stalls.
- Reset mid-DRAIN: drive rst=0 at k=N+2 → all outputs return to reset values at once. No further res_valid. A new len=1 frame with byte 7 afterwards returns 7, 7, 7.
- With BOE_SCHED_LOAD_TIMEOUT_EN defined and TIMEOUT=64: grant len=4, supply 2 bytes, then go idle → a rej pulse 64 cycles after the last accepted byte, state IDLE, no results.

Source files
------------

// File: rtl/boe_frame_sched.sv
// boe_frame_sched: round-robin sharing of one BOE statistics engine between two requesters.
// Define BOE_SCHED_LOAD_TIMEOUT_EN to abort a frame whose LOAD phase stalls for TIMEOUT cycles.
module boe_frame_sched #(
    parameter int DATA_W  = 8,
    parameter int RES_W   = 11,
    parameter int MAX_N   = 6,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [2:0]        len0,
    input  logic [2:0]        len1,
    input  logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] din1,
    input  logic              din_valid0,
    input  logic              din_valid1,
    output logic              din_ready0,
    output logic              din_ready1,
    output logic [RES_W-1:0]  res0,
    output logic [RES_W-1:0]  res1,
    output logic              res_valid0,
    output logic              res_valid1,
    output logic              res_last0,
    output logic              res_last1,
    output logic              rej0,
    output logic              rej1,
    output logic              eng_rst,
    output logic [2:0]        eng_data_num,
    output logic [DATA_W-1:0] eng_data_in,
    input  logic [RES_W-1:0]  eng_result,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, LOAD, BURST, DRAIN} state_t;

    localparam logic [2:0] MAX_N3 = 3'(MAX_N);

    state_t                  state_reg;
    logic                    owner_reg;
    logic                    rr_last_reg;
    logic [2:0]              n_reg;
    logic [2:0]              count_reg;
    logic [3:0]              k_reg;
    logic                    eng_rst_reg;
    logic [1:0][RES_W-1:0]   res_reg;
    logic [1:0]              res_valid_reg;
    logic [1:0]              res_last_reg;
    logic [DATA_W-1:0]       buf_reg [MAX_N];

    logic [1:0]              req_v;
    logic [1:0][2:0]         len_v;
    logic [1:0]              len_ok;
    logic [1:0]              elig;
    logic [1:0]              rdy_v;
    logic [1:0]              rej_v;
    logic                    grant_any;
    logic                    grant_id;
    logic [2:0]              len_sel;
    logic [DATA_W-1:0]       din_sel;
    logic                    valid_sel;
    logic                    accept;
    logic [3:0]              n_ext;
    logic                    cap;
    logic                    last_k;
    logic                    to_fire;

    assign req_v = {req1, req0};
    assign len_v = {len1, len0};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign len_ok[gi] = (len_v[gi] != 3'd0) && (len_v[gi] <= MAX_N3);
            assign elig[gi]   = req_v[gi] && len_ok[gi];
            assign rdy_v[gi]  = (state_reg == LOAD) && (owner_reg == 1'(gi)) && (count_reg < n_reg);
            // Illegal-length reject is only meaningful while idle and out of reset.
            assign rej_v[gi]  = (rst && (state_reg == IDLE) && req_v[gi] && !len_ok[gi])
                              || (to_fire && (owner_reg == 1'(gi)));
        end
    endgenerate

    // The requester that did not win last time has priority when both are eligible.
    assign grant_any = elig[0] | elig[1];
    assign grant_id  = rr_last_reg ? (~elig[0] & elig[1]) : elig[1];
    assign len_sel   = grant_id ? len1 : len0;

    assign din_sel   = owner_reg ? din1 : din0;
    assign valid_sel = owner_reg ? din_valid1 : din_valid0;
    assign accept    = (state_reg == LOAD) && valid_sel && (count_reg < n_reg);

    assign n_ext  = {1'b0, n_reg};
    assign cap    = (state_reg == DRAIN) && (k_reg >= n_ext + 4'd1);
    assign last_k = (state_reg == DRAIN) && (k_reg == (n_ext << 1) + 4'd2);

`ifdef BOE_SCHED_LOAD_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] to_cnt_reg;

    assign to_fire = (state_reg == LOAD) && !accept && (to_cnt_reg == TO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_reg <= '0;
        end else if ((state_reg == IDLE) || accept) begin
            to_cnt_reg <= '0;
        end else if (state_reg == LOAD) begin
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign to_fire        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (accept) begin
            buf_reg[count_reg] <= din_sel;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            owner_reg     <= 1'b0;
            rr_last_reg   <= 1'b1;
            n_reg         <= 3'd0;
            count_reg     <= 3'd0;
            k_reg         <= 4'd0;
            eng_rst_reg   <= 1'b1;
            res_reg       <= '0;
            res_valid_reg <= '0;
            res_last_reg  <= '0;
        end else begin
            res_valid_reg <= '0;
            res_last_reg  <= '0;
            case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        owner_reg   <= grant_id;
                        rr_last_reg <= grant_id;
                        n_reg       <= len_sel;
                        count_reg   <= 3'd0;
                        state_reg   <= LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        count_reg <= count_reg + 3'd1;
                        if (count_reg == n_reg - 3'd1) begin
                            state_reg   <= BURST;
                            eng_rst_reg <= 1'b0;
                            k_reg       <= 4'd0;
                        end
                    end else if (to_fire) begin
                        state_reg <= IDLE;
                    end
                end
                BURST: begin
                    k_reg <= k_reg + 4'd1;
                    if (k_reg == n_ext - 4'd1) begin
                        state_reg <= DRAIN;
                    end
                end
                default: begin
                    // DRAIN: engine output has fixed timing, so capture by cycle index alone.
                    k_reg <= k_reg + 4'd1;
                    if (cap) begin
                        res_reg[owner_reg]       <= eng_result;
                        res_valid_reg[owner_reg] <= 1'b1;
                        res_last_reg[owner_reg]  <= last_k;
                    end
                    if (last_k) begin
                        state_reg   <= IDLE;
                        eng_rst_reg <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign eng_rst      = eng_rst_reg;
    assign eng_data_num = (state_reg == BURST) ? n_reg : 3'd0;
    assign eng_data_in  = (state_reg == BURST) ? buf_reg[k_reg[2:0]] : '0;
    assign busy         = (state_reg != IDLE);

    assign din_ready0 = rdy_v[0];
    assign din_ready1 = rdy_v[1];
    assign rej0       = rej_v[0];
    assign rej1       = rej_v[1];
    assign res0       = res_reg[0];
    assign res1       = res_reg[1];
    assign res_valid0 = res_valid_reg[0];
    assign res_valid1 = res_valid_reg[1];
    assign res_last0  = res_last_reg[0];
    assign res_last1  = res_last_reg[1];

endmodule
